// File: rtl/imm_ext_stage.sv
// imm_ext_stage: registered immediate extender with branch mode, prefix combining, stall/flush.
// Optional BRANCH op (ext_op 011) is built only when EXT_BRANCH_EN is defined.
module imm_ext_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [2:0]       ext_op,
  output logic             out_valid,
  output logic [OUT_W-1:0] imm_out,
  output logic             prefix_armed
);
  localparam int PW = OUT_W - IN_W;
  typedef enum logic {IDLE, ARMED} state_t;
  state_t           state_q, state_d;
  logic [PW-1:0]    prefix_q, prefix_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] imm_q, imm_d;
  logic [OUT_W-1:0] zero_ext, sign_ext, upper_ext, branch_ext, ext_res;
  assign zero_ext  = {{PW{1'b0}}, imm_in};
  assign sign_ext  = {{PW{imm_in[IN_W-1]}}, imm_in};
  assign upper_ext = {imm_in, {PW{1'b0}}};
`ifdef EXT_BRANCH_EN
  assign branch_ext = {sign_ext[OUT_W-3:0], 2'b00};
`else
  assign branch_ext = '0;
`endif
  assign ext_res = ext_op == 3'b000 ? zero_ext  :
                   ext_op == 3'b001 ? sign_ext  :
                   ext_op == 3'b010 ? upper_ext :
                   ext_op == 3'b011 ? branch_ext : '0;
  always_comb begin
    state_d  = state_q;
    prefix_d = prefix_q;
    valid_d  = 1'b0;
    imm_d    = imm_q;
    if (flush) begin
      state_d  = IDLE;
      prefix_d = '0;
    end else if (stall) begin
      valid_d = valid_q;
    end else if (in_valid) begin
      if (ext_op == 3'b100) begin
        state_d  = ARMED;
        prefix_d = imm_in[PW-1:0];
      end else begin
        valid_d = 1'b1;
        imm_d   = state_q == ARMED ? {prefix_q, imm_in} : ext_res;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      prefix_q <= '0;
      valid_q  <= 1'b0;
      imm_q    <= '0;
    end else begin
      state_q  <= state_d;
      prefix_q <= prefix_d;
      valid_q  <= valid_d;
      imm_q    <= imm_d;
    end
  end
  assign out_valid    = valid_q;
  assign imm_out      = imm_q;
  assign prefix_armed = state_q == ARMED;
endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage: scoreboard bench for the 16->32 default and an 8->12 instance.
module tb_imm_ext_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset;
  logic        a_v, a_s, a_f, a_ov, a_pa;
  logic [15:0] a_imm;
  logic [2:0]  a_op;
  logic [31:0] a_out;
  logic        b_v, b_s, b_f, b_ov, b_pa;
  logic [7:0]  b_imm;
  logic [2:0]  b_op;
  logic [11:0] b_out;
  logic [31:0] q16[$];
  logic [11:0] q8[$];
  logic [31:0] last16;
  logic [11:0] last8;
  int n_chk = 0;
  int n_fail = 0;
  imm_ext_stage d16 (
    .clk(clk), .reset(reset), .in_valid(a_v), .stall(a_s), .flush(a_f),
    .imm_in(a_imm), .ext_op(a_op), .out_valid(a_ov), .imm_out(a_out), .prefix_armed(a_pa)
  );
  imm_ext_stage #(.IN_W(8), .OUT_W(12)) d8 (
    .clk(clk), .reset(reset), .in_valid(b_v), .stall(b_s), .flush(b_f),
    .imm_in(b_imm), .ext_op(b_op), .out_valid(b_ov), .imm_out(b_out), .prefix_armed(b_pa)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic sb_empty(input string tag);
    n_chk++;
    n_fail++;
    $error("FAIL %s: output valid but scoreboard empty", tag);
  endtask
  task automatic s16(input logic v, s, f, input logic [15:0] imm, input logic [2:0] op,
                     input logic ev, ea, pop, input string tag);
    a_v = v; a_s = s; a_f = f; a_imm = imm; a_op = op;
    @(posedge clk); #1;
    chk({tag, "/valid"}, 32'(a_ov), 32'(ev));
    chk({tag, "/armed"}, 32'(a_pa), 32'(ea));
    if (pop) begin
      if (q16.size() == 0) sb_empty(tag);
      else last16 = q16.pop_front();
    end
    chk({tag, "/imm"}, a_out, last16);
    a_v = 1'b0; a_s = 1'b0; a_f = 1'b0;
  endtask
  task automatic s8(input logic v, input logic [7:0] imm, input logic [2:0] op,
                    input logic ev, ea, pop, input string tag);
    b_v = v; b_imm = imm; b_op = op;
    @(posedge clk); #1;
    chk({tag, "/valid"}, 32'(b_ov), 32'(ev));
    chk({tag, "/armed"}, 32'(b_pa), 32'(ea));
    if (pop) begin
      if (q8.size() == 0) sb_empty(tag);
      else last8 = q8.pop_front();
    end
    chk({tag, "/imm"}, 32'(b_out), 32'(last8));
    b_v = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    a_v = 1'b0; a_s = 1'b0; a_f = 1'b0;
    b_v = 1'b0; b_s = 1'b0; b_f = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    last16 = '0;
    last8 = '0;
  endtask
  initial begin
    a_imm = '0; a_op = '0; b_imm = '0; b_op = '0;
    do_reset();
    do_reset();
    chk("rst/valid16", 32'(a_ov), 32'd0);
    chk("rst/armed16", 32'(a_pa), 32'd0);
    chk("rst/imm16", a_out, 32'd0);
    chk("rst/imm8", 32'(b_out), 32'd0);
    q16.push_back(32'hFFFF8001); s16(1, 0, 0, 16'h8001, 3'b001, 1, 0, 1, "sign");
    q16.push_back(32'h00008001); s16(1, 0, 0, 16'h8001, 3'b000, 1, 0, 1, "zero");
    q16.push_back(32'h12340000); s16(1, 0, 0, 16'h1234, 3'b010, 1, 0, 1, "upper");
`ifdef EXT_BRANCH_EN
    q16.push_back(32'hFFFFFFFC);
`else
    q16.push_back(32'h00000000);
`endif
    s16(1, 0, 0, 16'hFFFF, 3'b011, 1, 0, 1, "branch");
    s16(0, 0, 0, 16'h5555, 3'b001, 0, 0, 0, "idle_hold");
    s16(1, 0, 0, 16'hDEAD, 3'b100, 0, 1, 0, "prefix");
    q16.push_back(32'hDEADBEEF); s16(1, 0, 0, 16'hBEEF, 3'b001, 1, 0, 1, "combine");
    q16.push_back(32'h00000005); s16(1, 0, 0, 16'h0005, 3'b000, 1, 0, 1, "five");
    for (int i = 0; i < 3; i++) s16(1, 1, 0, 16'h0077, 3'b001, 1, 0, 0, "stall");
    s16(1, 1, 1, 16'h0099, 3'b000, 0, 0, 0, "flush_stall");
    s16(0, 0, 0, 16'h0000, 3'b000, 0, 0, 0, "after_flush");
    s16(1, 0, 0, 16'h00FF, 3'b100, 0, 1, 0, "pfx_flush");
    s16(0, 0, 1, 16'h0000, 3'b000, 0, 0, 0, "flush_armed");
    q16.push_back(32'h00000001); s16(1, 0, 0, 16'h0001, 3'b001, 1, 0, 1, "post_flush");
    s16(1, 0, 0, 16'h00FF, 3'b100, 0, 1, 0, "pfx_reset");
    do_reset();
    chk("rst_armed/armed", 32'(a_pa), 32'd0);
    chk("rst_armed/valid", 32'(a_ov), 32'd0);
    q16.push_back(32'h00000001); s16(1, 0, 0, 16'h0001, 3'b001, 1, 0, 1, "post_reset");
    s16(1, 0, 0, 16'hAAAA, 3'b100, 0, 1, 0, "pfx_a");
    s16(1, 0, 0, 16'h1111, 3'b100, 0, 1, 0, "pfx_over");
    q16.push_back(32'h11112222); s16(1, 0, 0, 16'h2222, 3'b000, 1, 0, 1, "pfx_last");
    q16.push_back(32'h00000000); s16(1, 0, 0, 16'hFFFF, 3'b110, 1, 0, 1, "rsv110");
    q16.push_back(32'h00000000); s16(1, 0, 0, 16'hFFFF, 3'b111, 1, 0, 1, "rsv111");
    s16(1, 0, 0, 16'h0BAD, 3'b100, 0, 1, 0, "pfx_stall");
    s16(0, 1, 0, 16'h0000, 3'b000, 0, 1, 0, "armed_stall");
    q16.push_back(32'h0BAD0001); s16(1, 0, 0, 16'h0001, 3'b010, 1, 0, 1, "pfx_any_op");
    q8.push_back(12'hF80); s8(1, 8'h80, 3'b001, 1, 0, 1, "w8_sign");
    s8(1, 8'hA5, 3'b100, 0, 1, 0, "w8_prefix");
    q8.push_back(12'h53C); s8(1, 8'h3C, 3'b000, 1, 0, 1, "w8_combine");
    q8.push_back(12'hAB0); s8(1, 8'hAB, 3'b010, 1, 0, 1, "w8_upper");
`ifdef EXT_BRANCH_EN
    q8.push_back(12'hE04);
`else
    q8.push_back(12'h000);
`endif
    s8(1, 8'h81, 3'b011, 1, 0, 1, "w8_branch");
    q8.push_back(12'h000); s8(1, 8'hFF, 3'b101, 1, 0, 1, "w8_rsv101");
    s8(0, 8'h00, 3'b000, 0, 0, 0, "w8_idle");
    chk("sb16_drained", 32'(q16.size()), 32'd0);
    chk("sb8_drained", 32'(q8.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imm_ext_stage.md
Name: imm_ext_stage

Overview:
Parametrised, registered immediate-extension stage for the decode pipeline. It sits between instruction decode and the D/E pipeline register. It generalises the fixed 16->32 extender in four ways: configurable widths, a branch-offset mode, a registered output with stall/flush control, and a two-instruction prefix mechanism that builds full-width immediates. Output is one cycle after acceptance.

Parameters:
IN_W, 16, immediate field width (>= 2)
OUT_W, 32, extended immediate width; constraint IN_W < OUT_W <= 2*IN_W
PW, OUT_W-IN_W (derived localparam), prefix width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  imm_in/ext_op valid this cycle
stall  in  1  hold all state (pipeline stall)
flush  in  1  discard output and prefix state (pipeline flush)
imm_in  in  IN_W  raw immediate field
ext_op  in  3  extension operation
out_valid  out  1  imm_out holds a fresh result
imm_out  out  OUT_W  extended immediate
prefix_armed  out  1  a prefix is held and waiting for its consumer

Behaviour:
- Reset: out_valid=0, imm_out=0, prefix_armed=0, prefix register=0, FSM=IDLE.
- Control priority at each edge: reset > flush > stall > normal.
- Accept: in_valid && !stall && !flush. Result registered; visible the next cycle (latency 1).
- ext_op encodings (IDLE state):
  - 000 ZERO: {PW zeros, imm_in}
  - 001 SIGN: {PW copies of imm_in[IN_W-1], imm_in}
  - 010 UPPER: imm_in placed in the top IN_W bits, zeros below. The result is truncated to OUT_W, so the low IN_W bits of {imm_in, IN_W zeros}[...] are dropped when OUT_W < 2*IN_W. Take the top OUT_W bits of {imm_in, IN_W zeros}.
  - 011 BRANCH: SIGN result shifted left 2, upper bits discarded (see Optional Feature).
  - 100 PREFIX: prefix_reg <= imm_in[PW-1:0]; FSM -> ARMED; out_valid <= 0 (bubble); imm_out holds.
  - 101-111: imm_out <= 0, out_valid <= 1.
- FSM states:
  - IDLE -> ARMED on an accepted PREFIX.
  - ARMED + accepted PREFIX -> stays ARMED; prefix_reg overwritten; out_valid <= 0.
  - ARMED + accepted non-PREFIX op: imm_out <= {prefix_reg, imm_in} regardless of op; out_valid <= 1; FSM -> IDLE.
  - prefix_armed = (FSM == ARMED), driven from the register.
- No accept, no stall, no flush: out_valid <= 0; imm_out and FSM hold.
- stall=1 (without flush): every register holds, including out_valid=1 and ARMED.
- flush=1: out_valid <= 0, FSM -> IDLE, prefix_reg <= 0. imm_out holds. This holds even when stall=1 or an in_valid arrives in the same cycle (that input is dropped).
- reset mid-prefix: returns to IDLE; the following op extends normally.

Optional Feature:
Macro EXT_BRANCH_EN.
- Defined: ext_op 011 performs BRANCH as above.
- Undefined: 011 falls into the reserved group: imm_out <= 0, out_valid <= 1. No shifter logic is synthesised.
- PREFIX combining is unaffected by this macro either way.

Test Plan:
Defaults, EXT_BRANCH_EN defined.
1. SIGN: imm_in=16'h8001, op=001, accept -> next cycle out_valid=1, imm_out=32'hFFFF8001. ZERO with the same imm -> 32'h00008001.
2. UPPER: imm_in=16'h1234, op=010 -> 32'h12340000. BRANCH: imm_in=16'hFFFF, op=011 -> 32'hFFFFFFFC.
3. Prefix: PREFIX 16'hDEAD, then SIGN 16'hBEEF on back-to-back cycles.
   - Cycle after the prefix: out_valid=0, prefix_armed=1.
   - Next cycle: imm_out=32'hDEADBEEF, out_valid=1, prefix_armed=0.
4. Stall/flush:
   - Result 32'h00000005 present, stall=1 for 3 cycles -> out_valid stays 1 and the value is unchanged.
   - flush=1 with stall=1 and in_valid=1 -> next cycle out_valid=0; the input is not captured.
5. Flush/reset while ARMED:
   - PREFIX 16'h00FF, then flush -> prefix_armed=0. A following SIGN 16'h0001 -> 32'h00000001.
   - Repeat with reset instead of flush -> same result.
6. Parametrisation and reserved ops:
   - IN_W=8, OUT_W=12: SIGN 8'h80 -> 12'hF80. PREFIX 8'hA5 then ZERO 8'h3C -> 12'h53C.
   - Reserved op 110 -> imm_out=0, out_valid=1.
   - Build without EXT_BRANCH_EN: op 011 -> 0.
